// File: rtl/wb_checkpoint_port.sv
// wb_checkpoint_port: Wishbone slave that queues 16-bit firmware checkpoints
// in a small FIFO and replays them onto mprj_io[31:16], holding each value
// for a programmable number of cycles so a slow external monitor sees it.
// Optional build macro WB_CHKPT_WDOG_EN adds an idle watchdog that drives
// 16'hDEAD when no checkpoint has been pushed within the WDOG limit.
module wb_checkpoint_port #(
  parameter int          FIFO_AW  = 2,
  parameter logic [15:0] HOLD_DEF = 16'd64
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               oe_en_q;
  logic               ovf_q;
  logic [15:0]        hold_q;
  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  state_t             state_q;
  logic [15:0]        cnt_q;
  logic [15:0]        io_out_q;

  logic        acc, wr_acc, rd_acc;
  logic [1:0]  word;
  logic        ctrl_wr, flush, push_req, stat_wr, hold_wr;
  logic [15:0] push_data;
  logic        empty, full, load, push_ok;
  logic [15:0] hold_eff;
  logic [31:0] rd_data;
  logic [15:0] wdog_lim_w;
  logic        wdog_fired_w;
  logic        wdog_hit;

  assign acc      = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_acc   = acc & wbs_we_i;
  assign rd_acc   = acc & ~wbs_we_i;
  assign word     = wbs_adr_i[3:2];

  assign ctrl_wr  = wr_acc && (word == 2'd0) && wbs_sel_i[0];
  assign flush    = ctrl_wr & wbs_dat_i[1];
  assign push_req = wr_acc && (word == 2'd1) && (|wbs_sel_i[1:0]);
  assign stat_wr  = wr_acc && (word == 2'd2) && wbs_sel_i[0];
  assign hold_wr  = wr_acc && (word == 2'd3);
  assign push_data = {wbs_sel_i[1] ? wbs_dat_i[15:8] : 8'h00,
                      wbs_sel_i[0] ? wbs_dat_i[7:0]  : 8'h00};

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign load     = !flush && !empty && ((state_q == ST_IDLE) || (cnt_q == 16'd0));
  assign push_ok  = push_req && (!full || load);
  assign hold_eff = (hold_q == 16'd0) ? 16'd1 : hold_q;

  assign io_out    = io_out_q;
  assign io_oeb    = {16{~oe_en_q}};
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

`ifdef WB_CHKPT_WDOG_EN
  logic [15:0] wdog_lim_q, wdog_cnt_q;
  logic        wdog_fired_q;
  logic        wdog_wr, wdog_clr;
  logic [1:0]  unused_bits;

  assign unused_bits  = wbs_adr_i[1:0];
  assign wdog_wr      = hold_wr && (|wbs_sel_i[3:2]);
  assign wdog_clr     = push_req | wdog_wr;
  assign wdog_hit     = !wdog_clr && (wdog_lim_q != 16'd0) && (wdog_cnt_q != wdog_lim_q)
                        && ((wdog_cnt_q + 16'd1) == wdog_lim_q);
  assign wdog_lim_w   = wdog_lim_q;
  assign wdog_fired_w = wdog_fired_q;

  // Idle watchdog: counts up to the limit since the last push, then parks and flags.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      wdog_lim_q   <= 16'd0;
      wdog_cnt_q   <= 16'd0;
      wdog_fired_q <= 1'b0;
    end else begin
      if (hold_wr && wbs_sel_i[2]) wdog_lim_q[7:0]  <= wbs_dat_i[23:16];
      if (hold_wr && wbs_sel_i[3]) wdog_lim_q[15:8] <= wbs_dat_i[31:24];
      if (wdog_clr)
        wdog_cnt_q <= 16'd0;
      else if ((wdog_lim_q != 16'd0) && (wdog_cnt_q != wdog_lim_q))
        wdog_cnt_q <= wdog_cnt_q + 16'd1;
      if (wdog_hit)
        wdog_fired_q <= 1'b1;
      else if (stat_wr && wbs_dat_i[3])
        wdog_fired_q <= 1'b0;
    end
  end
`else
  logic [21:0] unused_bits;

  assign unused_bits  = {wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_dat_i[3]};
  assign wdog_hit     = 1'b0;
  assign wdog_lim_w   = 16'd0;
  assign wdog_fired_w = 1'b0;
`endif

  // Read mux for the four word-addressed registers.
  always_comb begin
    rd_data = '0;
    case (word)
      2'd0: rd_data[0] = oe_en_q;
      2'd1: rd_data[15:0] = io_out_q;
      2'd2: begin
        rd_data[0]            = empty;
        rd_data[1]            = full;
        rd_data[2]            = ovf_q;
        rd_data[3]            = wdog_fired_w;
        rd_data[8+FIFO_AW:8]  = count_q;
      end
      default: rd_data = {wdog_lim_w, hold_q};
    endcase
  end

  // Bus handshake: one-cycle registered ack and read data captured with it.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= acc;
      dat_q <= rd_acc ? rd_data : 32'd0;
    end
  end

  // Control, hold and sticky overflow registers.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      oe_en_q <= 1'b0;
      hold_q  <= HOLD_DEF;
      ovf_q   <= 1'b0;
    end else begin
      if (ctrl_wr) oe_en_q <= wbs_dat_i[0];
      if (hold_wr && wbs_sel_i[0]) hold_q[7:0]  <= wbs_dat_i[7:0];
      if (hold_wr && wbs_sel_i[1]) hold_q[15:8] <= wbs_dat_i[15:8];
      if (push_req && !push_ok)
        ovf_q <= 1'b1;
      else if (stat_wr && wbs_dat_i[2])
        ovf_q <= 1'b0;
    end
  end

  // Checkpoint FIFO; a pop frees room for a push arriving in the same cycle.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (load) rptr_q <= rptr_q + 1'b1;
      case ({push_ok, load})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer: show each value for max(HOLD,1) cycles, reloading back-to-back.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      io_out_q <= 16'h0000;
    end else begin
      if (load)
        io_out_q <= mem_q[rptr_q];
      else if (wdog_hit)
        io_out_q <= 16'hDEAD;
      if (flush) begin
        state_q <= ST_IDLE;
      end else if (load) begin
        state_q <= ST_HOLD;
        cnt_q   <= hold_eff - 16'd1;
      end else if (state_q == ST_HOLD) begin
        if (cnt_q != 16'd0)
          cnt_q <= cnt_q - 16'd1;
        else
          state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_checkpoint_port.sv
// tb_wb_checkpoint_port: directed and randomized checks of wb_checkpoint_port
// against a queue-and-time-window reference model of the checkpoint port.
module tb_wb_checkpoint_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = 4'h0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat = 32'h0;
  logic [31:0] dat_o;
  logic        ack;
  logic [15:0] io_out, io_oeb;

  int nAssert = 0;
  int nFail = 0;
  int ab60Cycles = 0;

  // Reference model state: pending checkpoints, shown value and its display window.
  int          mq[$];
  logic [15:0] mOut;
  bit          mOe, mOvf, mFired, mShowing, mAckPrev;
  int          mHold, mWdogLim, mIdle;
  longint      mCycle, mWindowEnd;
  logic [31:0] mRdExp;

  wb_checkpoint_port dut (
    .wbs_clk_i(clk), .wbs_rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .io_out(io_out), .io_oeb(io_oeb)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOut = 16'h0; mOe = 0; mOvf = 0; mFired = 0; mShowing = 0; mAckPrev = 0;
    mHold = 64; mWdogLim = 0; mIdle = 0; mCycle = 0; mWindowEnd = 0; mRdExp = 0;
  endtask

  function automatic logic [31:0] modelRead(input int word);
    logic [31:0] r;
    int n;
    n = mq.size();
    case (word)
      0: r = {31'h0, mOe};
      1: r = {16'h0, mOut};
      2: r = (n << 8) | (int'(mFired) << 3) | (int'(mOvf) << 2) | (int'(n == 4) << 1) | int'(n == 0);
      default: r = {mWdogLim[15:0], mHold[15:0]};
    endcase
    return r;
  endfunction

  // One clock edge of the model, using the inputs the bench is presenting.
  task automatic modelStep();
    bit acc, flush, pushReq, popped;
    int word;
    acc = cyc && stb && !mAckPrev;
    mAckPrev = acc;
    word = int'(adr[3:2]);
    flush = acc && we && word == 0 && dat[1];
    pushReq = acc && we && word == 1;
    popped = 0;
    if (acc && !we) mRdExp = modelRead(word);
    if (flush) begin
      mShowing = 0;
      mq.delete();
    end else if (mq.size() > 0 && (!mShowing || mCycle >= mWindowEnd)) begin
      mOut = 16'(mq.pop_front());
      mShowing = 1;
      mWindowEnd = mCycle + ((mHold == 0) ? 1 : mHold);
      popped = 1;
    end
    if (pushReq) begin
      if (mq.size() < 4) mq.push_back(int'(dat[15:0]));
      else mOvf = 1;
    end
    if (acc && we) begin
      case (word)
        0: mOe = dat[0];
        2: begin
          if (dat[2]) mOvf = 0;
          if (dat[3]) mFired = 0;
        end
        3: begin
          mHold = int'(dat[15:0]);
`ifdef WB_CHKPT_WDOG_EN
          mWdogLim = int'(dat[31:16]);
`endif
        end
        default: ;
      endcase
    end
`ifdef WB_CHKPT_WDOG_EN
    if (pushReq || (acc && we && word == 3)) mIdle = 0;
    else if (mWdogLim != 0 && mIdle < mWdogLim) begin
      mIdle++;
      if (mIdle == mWdogLim) begin
        if (!popped) mOut = 16'hDEAD;
        mFired = 1;
      end
    end
`endif
    mCycle++;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    if (io_out === 16'hAB60) ab60Cycles++;
    checkOutput("io_out", {16'h0, io_out}, {16'h0, mOut});
    checkOutput("io_oeb", {16'h0, io_oeb}, {16'h0, {16{~mOe}}});
  endtask

  task automatic applyStimulus(input bit wr, input logic [3:0] a, input logic [31:0] d,
                               output logic [31:0] r);
    adr = a; dat = d; we = wr; cyc = 1'b1; stb = 1'b1;
    tick();
    checkOutput("ack", {31'h0, ack}, 32'h1);
    r = dat_o;
    if (!wr) checkOutput($sformatf("rdata_adr%0h", a), dat_o, mRdExp);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    checkOutput("ack_low", {31'h0, ack}, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    int k;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    checkOutput("rst_io_out", {16'h0, io_out}, 32'h0);
    checkOutput("rst_ack", {31'h0, ack}, 32'h0);
    checkOutput("rst_dat_o", dat_o, 32'h0);
    #3 rst_n = 1'b1;

    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("rst_status", r, 32'h00000001);
    applyStimulus(1, 4'h0, 32'h1, r);
    checkOutput("oe_enabled", {16'h0, io_oeb}, 32'h0);

    $display("[TB] hold=4, two back-to-back checkpoints");
    applyStimulus(1, 4'hC, 32'd4, r);
    applyStimulus(1, 4'h4, 32'hAB60, r);
    applyStimulus(1, 4'h4, 32'hAB61, r);
    repeat (20) tick();
    checkOutput("ab60_cycles", ab60Cycles, 4);
    checkOutput("ab61_held", {16'h0, io_out}, 32'hAB61);

    $display("[TB] hold=1000, fill FIFO and overflow");
    applyStimulus(1, 4'hC, 32'd1000, r);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 4'h4, 32'h1000 + i, r);
    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("full_no_ovf", r, 32'h00000402);
    applyStimulus(1, 4'h4, 32'h1006, r);
    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("ovf_set", r, 32'h00000406);
    applyStimulus(1, 4'h8, 32'h4, r);
    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("ovf_cleared", r, 32'h00000402);

    $display("[TB] flush");
    applyStimulus(1, 4'h0, 32'h3, r);
    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("flush_status", r, 32'h00000001);
    checkOutput("flush_io_out", {16'h0, io_out}, 32'h1001);

    $display("[TB] hold=0 consecutive values");
    applyStimulus(1, 4'hC, 32'd20, r);
    applyStimulus(1, 4'h4, 32'h9, r);
    for (int i = 1; i <= 3; i++) applyStimulus(1, 4'h4, i, r);
    applyStimulus(1, 4'hC, 32'd0, r);
    k = 0;
    while (io_out !== 16'h1 && k < 60) begin tick(); k++; end
    checkOutput("seq_1", {16'h0, io_out}, 32'h1);
    tick();
    checkOutput("seq_2", {16'h0, io_out}, 32'h2);
    tick();
    checkOutput("seq_3", {16'h0, io_out}, 32'h3);
    applyStimulus(0, 4'h4, 32'h0, r);
    checkOutput("push_readback", r, 32'h3);

    $display("[TB] async reset mid-hold");
    applyStimulus(1, 4'hC, 32'd50, r);
    applyStimulus(1, 4'h4, 32'h5555, r);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_io_out", {16'h0, io_out}, 32'h0);
    checkOutput("arst_io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    checkOutput("arst_ack", {31'h0, ack}, 32'h0);
    modelReset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1, 4'h0, 32'h1, r);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: applyStimulus(1, 4'h4, $urandom, r);
        5: applyStimulus(0, 4'($urandom_range(0, 3) << 2), 32'h0, r);
        6: applyStimulus(1, 4'hC, {16'($urandom_range(0, 3) * 16'd40), 16'($urandom_range(0, 6))}, r);
        7: applyStimulus(1, 4'h0, {30'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))}, r);
        8: applyStimulus(1, 4'h8, $urandom, r);
        default: repeat ($urandom_range(0, 8)) tick();
      endcase
    end

`ifdef WB_CHKPT_WDOG_EN
    $display("[TB] watchdog");
    applyStimulus(1, 4'h8, 32'hC, r);
    applyStimulus(1, 4'h0, 32'h3, r);
    applyStimulus(1, 4'hC, {16'd20, 16'd4}, r);
    repeat (25) tick();
    checkOutput("wdog_dead", {16'h0, io_out}, 32'hDEAD);
    applyStimulus(0, 4'h8, 32'h0, r);
    checkOutput("wdog_fired", {28'h0, r[3:0]}, 32'h9);
    applyStimulus(1, 4'h4, 32'hAB61, r);
    checkOutput("wdog_resume", {16'h0, io_out}, 32'hAB61);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
